// File: rtl/display_seq_pkg.sv
// Shared command encodings and sequencer state type for the display RAM sequencer.
package display_seq_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_SCROLL  = 2'b01;
    localparam logic [1:0] OP_CLRSCR  = 2'b10;
    localparam logic [1:0] OP_CLRLINE = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StScrRd,
        StScrWr,
        StFill,
        StDone
    } seq_state_e;

endpackage

// File: rtl/display_seq_addr_gen.sv
// Loadable address counter: holds a start/end pair, steps by one on advance and flags
// when the current address equals the end address.
module display_seq_addr_gen #(
    parameter int unsigned A_WIDTH = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [A_WIDTH-1:0] start_addr,
    input  logic [A_WIDTH-1:0] end_addr,
    output logic [A_WIDTH-1:0] addr,
    output logic               last
);

    logic [A_WIDTH-1:0] addr_q;
    logic [A_WIDTH-1:0] end_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q <= '0;
            end_q  <= '0;
        end else if (load) begin
            addr_q <= start_addr;
            end_q  <= end_addr;
        end else if (advance) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    assign addr = addr_q;
    // Exact-equal terminal compare: ranges never wrap the counter.
    assign last = (addr_q == end_q);

endmodule

// File: rtl/display_ram_sequencer.sv
// Port A owner for the display RAM: arbitrates host accesses against the scroll/clear engine.
// Optional cmd_abort input is enabled with `define DISPLAY_SEQ_ABORT_EN.
module display_ram_sequencer
    import display_seq_pkg::*;
#(
    parameter int unsigned         A_WIDTH = 11,
    parameter int unsigned         D_WIDTH = 8,
    parameter int unsigned         COLS    = 80,
    parameter int unsigned         ROWS    = 24,
    parameter logic [D_WIDTH-1:0]  BLANK   = 8'h20
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [A_WIDTH-1:0] host_addr,
    input  logic [D_WIDTH-1:0] host_wdata,
    output logic               host_ack,
    output logic               host_rvalid,
    output logic [D_WIDTH-1:0] host_rdata,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [4:0]         cmd_row,
`ifdef DISPLAY_SEQ_ABORT_EN
    input  logic               cmd_abort,
`endif
    output logic               cmd_ready,
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_wdata,
    output logic               ram_wren,
    input  logic [D_WIDTH-1:0] ram_q
);

    localparam logic [A_WIDTH-1:0] SCR_END    = A_WIDTH'(COLS * (ROWS - 1) - 1);
    localparam logic [A_WIDTH-1:0] FILL_START = A_WIDTH'(COLS * (ROWS - 1));
    localparam logic [A_WIDTH-1:0] SCREEN_END = A_WIDTH'(COLS * ROWS - 1);
    localparam logic [A_WIDTH-1:0] COLS_A     = A_WIDTH'(COLS);
    localparam logic [A_WIDTH-1:0] COLS_M1    = A_WIDTH'(COLS - 1);

    seq_state_e         state;
    logic               host_last;
    logic               fill_ok;
    logic               rvalid_q;
    logic [D_WIDTH-1:0] rdata_hold;

    logic               is_idle;
    logic               grant_host;
    logic               accept_cmd;
    logic               abort_req;
    logic               row_ok;
    logic [A_WIDTH-1:0] row_start;

    logic               ag_load;
    logic               ag_advance;
    logic [A_WIDTH-1:0] ag_start;
    logic [A_WIDTH-1:0] ag_end;
    logic [A_WIDTH-1:0] ag_addr;
    logic               ag_last;

`ifdef DISPLAY_SEQ_ABORT_EN
    assign abort_req = cmd_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign is_idle   = (state == StIdle) && reset_n;
    // Round-robin tie-break: the side that did not win last time wins a tie.
    assign grant_host = is_idle && host_req && (!cmd_valid || !host_last);
    assign accept_cmd = is_idle && cmd_valid && (!host_req || host_last);
    assign host_ack   = grant_host;
    assign cmd_ready  = is_idle && (!host_req || host_last);

    assign row_ok    = (32'(cmd_row) < ROWS);
    assign row_start = A_WIDTH'(32'(cmd_row) * COLS);

    always_comb begin
        ag_load    = 1'b0;
        ag_advance = 1'b0;
        ag_start   = '0;
        ag_end     = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_wren   = 1'b0;
        case (state)
            StIdle: begin
                if (accept_cmd) begin
                    ag_load = 1'b1;
                    case (cmd_op)
                        OP_SCROLL: begin
                            ag_start = '0;
                            ag_end   = SCR_END;
                        end
                        OP_CLRSCR: begin
                            ag_start = '0;
                            ag_end   = SCREEN_END;
                        end
                        OP_CLRLINE: begin
                            ag_start = row_start;
                            ag_end   = row_start + COLS_M1;
                        end
                        default: ag_load = 1'b0;
                    endcase
                end
                if (grant_host) begin
                    ram_addr  = host_addr;
                    ram_wdata = host_wdata;
                    ram_wren  = host_we;
                end
            end
            StScrRd: begin
                ram_addr = ag_addr + COLS_A;
            end
            StScrWr: begin
                ram_addr  = ag_addr;
                ram_wdata = ram_q;
                ram_wren  = 1'b1;
                if (ag_last) begin
                    ag_load  = 1'b1;
                    ag_start = FILL_START;
                    ag_end   = SCREEN_END;
                end else begin
                    ag_advance = 1'b1;
                end
            end
            StFill: begin
                ram_addr   = ag_addr;
                ram_wdata  = BLANK;
                ram_wren   = fill_ok;
                ag_advance = 1'b1;
            end
            default: ;
        endcase
        if (!reset_n) begin
            ram_addr  = '0;
            ram_wdata = '0;
            ram_wren  = 1'b0;
        end
    end

    display_seq_addr_gen #(
        .A_WIDTH(A_WIDTH)
    ) u_addr_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ag_load),
        .advance   (ag_advance),
        .start_addr(ag_start),
        .end_addr  (ag_end),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            host_last  <= 1'b0;
            fill_ok    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_hold <= '0;
        end else begin
            done     <= 1'b0;
            rvalid_q <= grant_host && !host_we;
            if (rvalid_q) begin
                rdata_hold <= ram_q;
            end
            case (state)
                StIdle: begin
                    if (accept_cmd) begin
                        host_last <= 1'b0;
                        busy      <= 1'b1;
                        fill_ok   <= 1'b1;
                        case (cmd_op)
                            OP_SCROLL:  state <= StScrRd;
                            OP_CLRSCR:  state <= StFill;
                            OP_CLRLINE: begin
                                // Out-of-range row spends one idle FILL cycle, no writes.
                                state   <= StFill;
                                fill_ok <= row_ok;
                            end
                            default: begin
                                state <= StDone;
                                done  <= 1'b1;
                            end
                        endcase
                    end else if (grant_host) begin
                        host_last <= 1'b1;
                    end
                end
                StScrRd: begin
                    if (abort_req) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        state <= StScrWr;
                    end
                end
                StScrWr: begin
                    if (abort_req) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (ag_last) begin
                        state <= StFill;
                    end else begin
                        state <= StScrRd;
                    end
                end
                StFill: begin
                    if (abort_req || ag_last || !fill_ok) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign host_rvalid = rvalid_q;
    // RAM output is valid in the rvalid cycle; the hold register keeps it afterwards.
    assign host_rdata  = rvalid_q ? ram_q : rdata_hold;

endmodule
